// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port and decode handshake of instr_fetch_unit.
// master = fetch unit side, slave = memory/decode side.
interface instr_fetch_unit_if;
  logic       imem_rd;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       ir_valid;
  logic       ir_ready;
  logic [7:0] ir_opcode;
  logic [7:0] ir_imm;
  logic       ir_two_byte;
  logic [7:0] ir_pc;

  modport master (
    output imem_rd, imem_addr,
    input  imem_rdata,
    output ir_valid, ir_opcode, ir_imm, ir_two_byte, ir_pc,
    input  ir_ready
  );

  modport slave (
    input  imem_rd, imem_addr,
    output imem_rdata,
    input  ir_valid, ir_opcode, ir_imm, ir_two_byte, ir_pc,
    output ir_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Boot-vector loader and 1/2-byte instruction fetch sequencer feeding decode.
// Optional retired-fetch counter enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter logic [3:0] TWO_BYTE_MIN = 4'hC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pc,
  output logic        pc_write,
  output logic        pc_increment,
  output logic        pc_load_vec,
  output logic [7:0]  reset_vector,
  output logic [7:0]  intr_vector,
  input  logic        flush,
  output logic [15:0] instr_count,
  instr_fetch_unit_if.master bus
);

  localparam logic [2:0] VEC0   = 3'd0;
  localparam logic [2:0] VEC1   = 3'd1;
  localparam logic [2:0] VECW   = 3'd2;
  localparam logic [2:0] LOADPC = 3'd3;
  localparam logic [2:0] FETCH0 = 3'd4;
  localparam logic [2:0] OPC    = 3'd5;
  localparam logic [2:0] IMM    = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

  logic [2:0] state_q, state_d;
  logic [7:0] reset_vector_q, reset_vector_d;
  logic [7:0] intr_vector_q, intr_vector_d;
  logic [7:0] ir_opcode_q, ir_opcode_d;
  logic [7:0] ir_imm_q, ir_imm_d;
  logic       ir_two_byte_q, ir_two_byte_d;
  logic [7:0] ir_pc_q, ir_pc_d;
  logic       rd;
  logic [7:0] addr;
  logic       opc_two_byte;

  assign opc_two_byte = (bus.imem_rdata[7:4] >= TWO_BYTE_MIN);

  always_comb begin
    state_d        = state_q;
    reset_vector_d = reset_vector_q;
    intr_vector_d  = intr_vector_q;
    ir_opcode_d    = ir_opcode_q;
    ir_imm_d       = ir_imm_q;
    ir_two_byte_d  = ir_two_byte_q;
    ir_pc_d        = ir_pc_q;
    rd             = 1'b0;
    addr           = '0;
    pc_write       = 1'b0;
    pc_load_vec    = 1'b0;
    case (state_q)
      VEC0: begin
        rd      = 1'b1;
        addr    = 8'd0;
        state_d = VEC1;
      end
      VEC1: begin
        rd             = 1'b1;
        addr           = 8'd1;
        reset_vector_d = bus.imem_rdata;
        state_d        = VECW;
      end
      VECW: begin
        intr_vector_d = bus.imem_rdata;
        state_d       = LOADPC;
      end
      LOADPC: begin
        pc_load_vec = 1'b1;
        state_d     = FETCH0;
      end
      FETCH0: begin
        if (!flush) begin
          rd      = 1'b1;
          addr    = pc;
          ir_pc_d = pc;
          state_d = OPC;
        end
      end
      OPC: begin
        if (flush) begin
          state_d = FETCH0;
        end else begin
          ir_opcode_d   = bus.imem_rdata;
          ir_two_byte_d = opc_two_byte;
          if (opc_two_byte) begin
            // Immediate address wraps within the 8-bit space.
            rd      = 1'b1;
            addr    = ir_pc_q + 8'd1;
            state_d = IMM;
          end else begin
            ir_imm_d = '0;
            state_d  = DONE;
          end
        end
      end
      IMM: begin
        if (flush) begin
          state_d = FETCH0;
        end else begin
          ir_imm_d = bus.imem_rdata;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (flush) begin
          state_d = FETCH0;
        end else if (bus.ir_ready) begin
          pc_write = 1'b1;
          state_d  = FETCH0;
        end
      end
      default: state_d = VEC0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= VEC0;
      reset_vector_q <= '0;
      intr_vector_q  <= '0;
      ir_opcode_q    <= '0;
      ir_imm_q       <= '0;
      ir_two_byte_q  <= 1'b0;
      ir_pc_q        <= '0;
    end else begin
      state_q        <= state_d;
      reset_vector_q <= reset_vector_d;
      intr_vector_q  <= intr_vector_d;
      ir_opcode_q    <= ir_opcode_d;
      ir_imm_q       <= ir_imm_d;
      ir_two_byte_q  <= ir_two_byte_d;
      ir_pc_q        <= ir_pc_d;
    end
  end

  // VEC0 is the reset state; masking with rst keeps the strobe quiet while held.
  assign bus.imem_rd     = rd & ~rst;
  assign bus.imem_addr   = addr;
  assign bus.ir_valid    = (state_q == DONE);
  assign bus.ir_opcode   = ir_opcode_q;
  assign bus.ir_imm      = ir_imm_q;
  assign bus.ir_two_byte = ir_two_byte_q;
  assign bus.ir_pc       = ir_pc_q;
  assign pc_increment    = pc_write & ir_two_byte_q;
  assign reset_vector    = reset_vector_q;
  assign intr_vector     = intr_vector_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] instr_count_q, instr_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    if ((state_q == DONE) && bus.ir_ready && !flush)
      instr_count_d = instr_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) instr_count_q <= '0;
    else     instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory + PC models, scoreboard of expected instructions.
module tb_instr_fetch_unit;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  imm;
    logic        two;
    int unsigned len;
  } vec_t;

  typedef struct {
    logic [7:0] op;
    logic [7:0] imm;
    logic       two;
    logic [7:0] pc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  pc;
  logic        pc_write;
  logic        pc_increment;
  logic        pc_load_vec;
  logic [7:0]  reset_vector;
  logic [7:0]  intr_vector;
  logic        flush;
  logic [15:0] instr_count;

  logic        redir_en;
  logic [7:0]  redir_val;
  logic [7:0]  mem [256];

  int          checks;
  int          failures;
  int          cyc;
  int          hs_cnt;
  int          pw_cnt;
  int          last_hs_cyc;
  logic [15:0] exp_cnt;
  exp_t        sb [$];
  vec_t        tbl [6];

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.TWO_BYTE_MIN(4'hC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_write     (pc_write),
    .pc_increment (pc_increment),
    .pc_load_vec  (pc_load_vec),
    .reset_vector (reset_vector),
    .intr_vector  (intr_vector),
    .flush        (flush),
    .instr_count  (instr_count),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_rdata <= mem[bus.imem_addr];
  end

  // Program counter model: external redirect, vector load, +1/+2 advance.
  always @(posedge clk) begin
    if (redir_en)         pc <= redir_val;
    else if (pc_load_vec) pc <= reset_vector;
    else if (pc_write)    pc <= pc + (pc_increment ? 8'd2 : 8'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] exp_ic();
`ifdef FETCH_PERF_CNT_EN
    return exp_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout/none expected event", name);
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] imm, input logic two, input logic [7:0] a);
    exp_t e;
    e.op = op; e.imm = imm; e.two = two; e.pc = a;
    sb.push_back(e);
  endtask

  // Samples at the falling edge; retires scoreboard entries on handshakes.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (pc_load_vec) chk("load_vs_write", {31'd0, pc_write}, 32'd0);
    if (bus.ir_valid && bus.ir_ready && !flush) begin
      chk("instr_count", {16'd0, instr_count}, {16'd0, exp_ic()});
      if (sb.size() == 0) begin
        fail_now("unexpected_instr");
      end else begin
        e = sb.pop_front();
        chk("ir_opcode", {24'd0, bus.ir_opcode}, {24'd0, e.op});
        chk("ir_imm", {24'd0, bus.ir_imm}, {24'd0, e.imm});
        chk("ir_two_byte", {31'd0, bus.ir_two_byte}, {31'd0, e.two});
        chk("ir_pc", {24'd0, bus.ir_pc}, {24'd0, e.pc});
        chk("pc_write_hs", {31'd0, pc_write}, 32'd1);
        chk("pc_increment", {31'd0, pc_increment}, {31'd0, e.two});
      end
      hs_cnt++;
      exp_cnt = exp_cnt + 16'd1;
      last_hs_cyc = cyc;
    end else if (pc_write) begin
      chk("pc_write_spurious", {31'd0, pc_write}, 32'd0);
    end
    if (pc_write) pw_cnt++;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int unsigned budget);
    int start;
    bit done;
    start = hs_cnt;
    done  = 1'b0;
    for (int unsigned k = 0; k < budget; k++) begin
      sample();
      done = (hs_cnt > start);
      adv();
      if (done) break;
    end
    if (!done) fail_now("timeout_handshake");
  endtask

  // Returns at the falling edge of the first cycle with ir_valid high.
  task automatic wait_valid(input int unsigned budget);
    bit found;
    found = 1'b0;
    for (int unsigned k = 0; k < budget; k++) begin
      sample();
      if (bus.ir_valid) begin
        found = 1'b1;
        break;
      end
      adv();
    end
    if (!found) fail_now("timeout_valid");
  endtask

  // Called just after rst is released; returns with the first fetch issued.
  task automatic boot_check(input logic [7:0] rv, input logic [7:0] iv);
    sample();
    chk("boot_c1_rd", {23'd0, bus.imem_rd, bus.imem_addr}, {23'd0, 1'b1, 8'h00});
    chk("boot_c1_load", {31'd0, pc_load_vec}, 32'd0);
    adv();
    sample();
    chk("boot_c2_rd", {23'd0, bus.imem_rd, bus.imem_addr}, {23'd0, 1'b1, 8'h01});
    chk("boot_c2_load", {31'd0, pc_load_vec}, 32'd0);
    adv();
    sample();
    chk("reset_vector", {24'd0, reset_vector}, {24'd0, rv});
    chk("boot_c3_load", {31'd0, pc_load_vec}, 32'd0);
    adv();
    sample();
    chk("boot_c4_load", {31'd0, pc_load_vec}, 32'd1);
    chk("intr_vector", {24'd0, intr_vector}, {24'd0, iv});
    adv();
    sample();
    chk("boot_c5_load", {31'd0, pc_load_vec}, 32'd0);
    chk("first_fetch", {23'd0, bus.imem_rd, bus.imem_addr}, {23'd0, 1'b1, rv});
    adv();
  endtask

  initial begin
    logic [7:0] a;
    int prev;
    int pw_before;

    checks = 0; failures = 0; cyc = 0; hs_cnt = 0; pw_cnt = 0; last_hs_cyc = 0;
    exp_cnt = '0;
    rst = 1'b1; flush = 1'b0; redir_en = 1'b0; redir_val = '0;
    bus.ir_ready = 1'b0;
    bus.imem_rdata = '0;
    pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h10;
    mem[1] = 8'h80;

    tbl[0] = '{op: 8'h25, imm: 8'h00, two: 1'b0, len: 3};
    tbl[1] = '{op: 8'hC3, imm: 8'h5A, two: 1'b1, len: 4};
    tbl[2] = '{op: 8'h7F, imm: 8'h00, two: 1'b0, len: 3};
    tbl[3] = '{op: 8'hF0, imm: 8'h11, two: 1'b1, len: 4};
    tbl[4] = '{op: 8'hBB, imm: 8'h00, two: 1'b0, len: 3};
    tbl[5] = '{op: 8'hC0, imm: 8'hFF, two: 1'b1, len: 4};
    a = 8'h10;
    for (int i = 0; i < 6; i++) begin
      mem[a] = tbl[i].op;
      if (tbl[i].two) mem[a + 8'd1] = tbl[i].imm;
      push(tbl[i].op, tbl[i].imm, tbl[i].two, a);
      a = a + (tbl[i].two ? 8'd2 : 8'd1);
    end
    mem[8'h19] = 8'h42;
    mem[8'h1A] = 8'h01;
    mem[8'hFF] = 8'hC3;
    mem[8'h30] = 8'hD1;
    mem[8'h31] = 8'h22;
    mem[8'h40] = 8'h05;
    mem[8'h41] = 8'hE7;
    mem[8'h42] = 8'h99;

    adv();
    adv();
    sample();
    chk("rst_outputs", {26'd0, bus.imem_rd, bus.ir_valid, pc_write, pc_load_vec, pc_increment, bus.ir_two_byte}, 32'd0);
    chk("rst_vectors", {16'd0, reset_vector, intr_vector}, 32'd0);
    chk("rst_ir", {bus.ir_opcode, bus.ir_imm, bus.ir_pc, 8'd0}, 32'd0);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    adv();

    rst = 1'b0;
    boot_check(8'h10, 8'h80);

    // Table-driven straight-line program at full ready.
    bus.ir_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      wait_hs(10);
      if (i > 0) chk("throughput", last_hs_cyc - prev, tbl[i].len);
      prev = last_hs_cyc;
    end
    bus.ir_ready = 1'b0;

    // Backpressure: five DONE cycles without ready.
    push(8'h42, 8'h00, 1'b0, 8'h19);
    wait_valid(10);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {14'd0, bus.ir_valid, bus.imem_rd, pc_write, 1'b0, bus.ir_opcode, bus.ir_pc},
          {14'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h42, 8'h19});
      adv();
      if (k < 4) sample();
    end
    pw_before = pw_cnt;
    bus.ir_ready = 1'b1;
    sample();
    adv();
    bus.ir_ready = 1'b0;
    wait_valid(10);
    adv();
    chk("bp_single_write", pw_cnt - pw_before, 1);

    // Flush together with ready in DONE, redirect to FF for the wrap case.
    mem[8'h00] = 8'h5A;
    bus.ir_ready = 1'b1;
    flush = 1'b1;
    redir_en = 1'b1;
    redir_val = 8'hFF;
    sample();
    chk("flush_beats_ready", {31'd0, pc_write}, 32'd0);
    chk("flush_valid_still", {31'd0, bus.ir_valid}, 32'd1);
    adv();
    flush = 1'b0;
    redir_en = 1'b0;
    push(8'hC3, 8'h5A, 1'b1, 8'hFF);
    sample();
    chk("flush_valid_drop", {31'd0, bus.ir_valid}, 32'd0);
    chk("wrap_fetch_addr", {24'd0, bus.imem_addr}, 32'hFF);
    chk("flush_count", {16'd0, instr_count}, {16'd0, exp_ic()});
    adv();
    wait_hs(10);
    bus.ir_ready = 1'b0;

    // Flush during OPC of a 2-byte fetch at 30.
    wait_valid(10);
    adv();
    flush = 1'b1;
    redir_en = 1'b1;
    redir_val = 8'h30;
    sample();
    adv();
    flush = 1'b0;
    redir_en = 1'b0;
    sample();
    chk("redir_fetch", {23'd0, bus.imem_rd, bus.imem_addr}, {23'd0, 1'b1, 8'h30});
    adv();
    flush = 1'b1;
    redir_en = 1'b1;
    redir_val = 8'h40;
    sample();
    chk("opc_flush_no_read", {30'd0, bus.imem_rd, bus.ir_valid}, 32'd0);
    adv();
    flush = 1'b0;
    redir_en = 1'b0;
    bus.ir_ready = 1'b1;
    push(8'h05, 8'h00, 1'b0, 8'h40);
    wait_hs(10);
    bus.ir_ready = 1'b0;

    // Reset while in IMM of the E7 99 fetch at 41.
    sample();
    chk("fetch41", {23'd0, bus.imem_rd, bus.imem_addr}, {23'd0, 1'b1, 8'h41});
    adv();
    sample();
    chk("imm_read_addr", {23'd0, bus.imem_rd, bus.imem_addr}, {23'd0, 1'b1, 8'h42});
    adv();
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {26'd0, bus.imem_rd, bus.ir_valid, pc_write, pc_load_vec, pc_increment, bus.ir_two_byte}, 32'd0);
    chk("midrst_vectors", {16'd0, reset_vector, intr_vector}, 32'd0);
    chk("midrst_ir", {bus.ir_opcode, bus.ir_imm, bus.ir_pc, 8'd0}, 32'd0);
    chk("midrst_count", {16'd0, instr_count}, 32'd0);
    exp_cnt = '0;
    mem[8'h00] = 8'h20;
    mem[8'h01] = 8'h90;
    mem[8'h20] = 8'h33;
    adv();
    adv();
    rst = 1'b0;
    boot_check(8'h20, 8'h90);
    bus.ir_ready = 1'b1;
    push(8'h33, 8'h00, 1'b0, 8'h20);
    wait_hs(10);
    bus.ir_ready = 1'b0;
    chk("sb_drained", sb.size(), 0);
    sample();
    chk("final_count", {16'd0, instr_count}, {16'd0, exp_ic()});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
